// File: rtl/cipher_datapath.sv
`default_nettype none
// ============================================================================
// Module   : cipher_datapath
// Purpose  : Byte datapath that follows the 2-phase encode/decode controller.
//            It loads two bytes, derives an 8-bit key in two rounds, then
//            encodes or decodes byte A. It tracks the controller sequence
//            itself and refuses to act on illegal codes or transitions.
// Revision : 1.0 - initial release
// ============================================================================
module cipher_datapath #(
    parameter logic [7:0]  KEY_CONST = 8'hA5,
    parameter logic [7:0]  ROUND_ADD = 8'h3C,
    parameter int unsigned ROT       = 3      // meaningful range 1..7
) (
    input  logic       clka,
    input  logic       restart_n,
    input  logic [2:0] state,
    input  logic [7:0] data_in,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic [7:0] key,
    output logic       seq_err,
    output logic [7:0] op_count
);

    // Controller state codes
    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LB1  = 3'b101;
    localparam logic [2:0] S_LB2  = 3'b110;
    localparam logic [2:0] S_KG1  = 3'b001;
    localparam logic [2:0] S_KG2  = 3'b010;
    localparam logic [2:0] S_ENC  = 3'b011;
    localparam logic [2:0] S_DEC  = 3'b100;

    logic [2:0] prev_state;
    logic [7:0] byte_a;
    logic [7:0] byte_b;

    logic       entry;
    logic       legal;
    logic [7:0] enc_result;
    logic [7:0] dec_result;
    logic [7:0] kg1_result;
    logic [7:0] kg2_result;

    // Rotate an 8-bit value left by n (0..7) using a doubled copy.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] tmp;
        tmp = {x, x} << n;
        return tmp[15:8];
    endfunction

    // Rotate an 8-bit value right by n (0..7) using a doubled copy.
    function automatic logic [7:0] rotr8(input logic [7:0] x, input int unsigned n);
        logic [15:0] tmp;
        tmp = {x, x} >> n;
        return tmp[7:0];
    endfunction

    // Entry detection and transition legality against the tracked previous code.
    // Moving to IDLE is always allowed; code 111 never matches a legal entry.
    always_comb begin
        entry = (state != prev_state);
        legal = 1'b0;
        if (state == S_IDLE) begin
            legal = 1'b1;
        end else begin
            case (prev_state)
                S_IDLE:  legal = (state == S_LB1);
                S_LB1:   legal = (state == S_LB2);
                S_LB2:   legal = (state == S_KG1);
                S_KG1:   legal = (state == S_KG2);
                S_KG2:   legal = (state == S_ENC) || (state == S_DEC);
                default: legal = 1'b0;
            endcase
        end
    end

    // Byte arithmetic for each action.
    always_comb begin
        kg1_result = {byte_b[3:0], byte_b[7:4]} ^ KEY_CONST;
        kg2_result = rotl8(key, 1) + ROUND_ADD;
        enc_result = rotl8(byte_a ^ key, ROT);
        dec_result = rotr8(byte_a, ROT) ^ key;
    end

    // Sequence tracking, error flag and per-state register actions.
    // An illegal entry forces prev_state back to IDLE so only IDLE or LB1
    // can legally follow it.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            prev_state <= S_IDLE;
            byte_a     <= 8'h00;
            byte_b     <= 8'h00;
            key        <= 8'h00;
            data_out   <= 8'h00;
            out_valid  <= 1'b0;
            seq_err    <= 1'b0;
            op_count   <= 8'h00;
        end else begin
            out_valid  <= 1'b0;
            prev_state <= state;
            if (clr_err) begin
                seq_err <= 1'b0;
            end
            if (entry) begin
                if (!legal) begin
                    // A new error overrides a simultaneous clear.
                    seq_err    <= 1'b1;
                    prev_state <= S_IDLE;
                end else begin
                    case (state)
                        S_LB1: byte_a <= data_in;
                        S_LB2: byte_b <= data_in;
                        S_KG1: key    <= kg1_result;
                        S_KG2: key    <= kg2_result;
                        S_ENC: begin
                            data_out  <= enc_result;
                            out_valid <= 1'b1;
                            if (op_count != 8'hFF) begin
                                op_count <= op_count + 8'd1;
                            end
                        end
                        S_DEC: begin
                            data_out  <= dec_result;
                            out_valid <= 1'b1;
                            if (op_count != 8'hFF) begin
                                op_count <= op_count + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cipher_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_datapath
// Purpose  : Directed self-checking bench for cipher_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_datapath;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LB1  = 3'b101;
    localparam logic [2:0] S_LB2  = 3'b110;
    localparam logic [2:0] S_KG1  = 3'b001;
    localparam logic [2:0] S_KG2  = 3'b010;
    localparam logic [2:0] S_ENC  = 3'b011;
    localparam logic [2:0] S_DEC  = 3'b100;
    localparam logic [2:0] S_BAD  = 3'b111;

    logic       clka = 1'b0;
    logic       restart_n;
    logic [2:0] state;
    logic [7:0] data_in;
    logic       clr_err;
    logic [7:0] data_out;
    logic       out_valid;
    logic [7:0] key;
    logic       seq_err;
    logic [7:0] op_count;

    int tests_run    = 0;
    int tests_failed = 0;

    cipher_datapath dut (
        .clka      (clka),
        .restart_n (restart_n),
        .state     (state),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .out_valid (out_valid),
        .key       (key),
        .seq_err   (seq_err),
        .op_count  (op_count)
    );

    always #5 clka = ~clka;

    // Drive a code at the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic [2:0] code, input logic [7:0] d);
        @(negedge clka);
        state   = code;
        data_in = d;
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clka);
        restart_n = 1'b0;
        #2;
        tests_run++;
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out got %h want 00", data_out); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (key !== 8'h00) begin tests_failed++; $display("FAIL reset_key got %h want 00", key); end
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
        tests_run++;
        if (op_count !== 8'h00) begin tests_failed++; $display("FAIL reset_op_count got %h want 00", op_count); end
        @(negedge clka);
        restart_n = 1'b1;
        step(S_IDLE, 8'h00);
        // IDLE held after reset must not raise an error
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_err got %b want 0", seq_err); end
    endtask

    task automatic test_encode;
        step(S_LB1, 8'h48);
        step(S_LB2, 8'h1F);
        step(S_KG1, 8'h00);
        tests_run++;
        if (key !== 8'h54) begin tests_failed++; $display("FAIL enc_key1 got %h want 54", key); end
        step(S_KG2, 8'h00);
        tests_run++;
        if (key !== 8'hE4) begin tests_failed++; $display("FAIL enc_key2 got %h want E4", key); end
        step(S_ENC, 8'h00);
        tests_run++;
        if (data_out !== 8'h65) begin tests_failed++; $display("FAIL enc_data got %h want 65", data_out); end
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL enc_valid got %b want 1", out_valid); end
        tests_run++;
        if (op_count !== 8'h01) begin tests_failed++; $display("FAIL enc_count got %h want 01", op_count); end
        step(S_IDLE, 8'h00);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL enc_valid_drop got %b want 0", out_valid); end
        tests_run++;
        if (data_out !== 8'h65) begin tests_failed++; $display("FAIL enc_data_hold got %h want 65", data_out); end
    endtask

    task automatic test_decode;
        step(S_LB1, 8'h65);
        step(S_LB2, 8'h1F);
        step(S_KG1, 8'h00);
        step(S_KG2, 8'h00);
        step(S_DEC, 8'h00);
        tests_run++;
        if (data_out !== 8'h48) begin tests_failed++; $display("FAIL dec_data got %h want 48", data_out); end
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dec_valid got %b want 1", out_valid); end
        tests_run++;
        if (op_count !== 8'h02) begin tests_failed++; $display("FAIL dec_count got %h want 02", op_count); end
        step(S_IDLE, 8'h00);
    endtask

    task automatic test_hold;
        logic [2:0] seq [5];
        logic [7:0] dat [5];
        int pulses;
        seq[0] = S_LB1; dat[0] = 8'h48;
        seq[1] = S_LB2; dat[1] = 8'h1F;
        seq[2] = S_KG1; dat[2] = 8'h00;
        seq[3] = S_KG2; dat[3] = 8'h00;
        seq[4] = S_ENC; dat[4] = 8'h00;
        pulses = 0;
        for (int s = 0; s < 5; s++) begin
            for (int h = 0; h < 3; h++) begin
                // data_in changes while held; only the entry cycle may sample it
                step(seq[s], (h == 0) ? dat[s] : 8'hFF);
                if (out_valid === 1'b1) pulses++;
            end
        end
        step(S_IDLE, 8'h00);
        if (out_valid === 1'b1) pulses++;
        tests_run++;
        if (pulses != 1) begin tests_failed++; $display("FAIL hold_pulses got %0d want 1", pulses); end
        tests_run++;
        if (key !== 8'hE4) begin tests_failed++; $display("FAIL hold_key got %h want E4", key); end
        tests_run++;
        if (data_out !== 8'h65) begin tests_failed++; $display("FAIL hold_data got %h want 65", data_out); end
        tests_run++;
        if (op_count !== 8'h03) begin tests_failed++; $display("FAIL hold_count got %h want 03", op_count); end
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL hold_err got %b want 0", seq_err); end
    endtask

    task automatic test_errors;
        // a) IDLE -> KG1 skips the loads
        step(S_KG1, 8'h00);
        tests_run++;
        if (seq_err !== 1'b1) begin tests_failed++; $display("FAIL err_a_flag got %b want 1", seq_err); end
        tests_run++;
        if (key !== 8'hE4) begin tests_failed++; $display("FAIL err_a_key got %h want E4", key); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL err_a_valid got %b want 0", out_valid); end
        step(S_IDLE, 8'h00);
        // c) clear
        clr_err = 1'b1;
        step(S_IDLE, 8'h00);
        clr_err = 1'b0;
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL err_clr1 got %b want 0", seq_err); end
        // b) illegal code
        step(S_BAD, 8'h00);
        tests_run++;
        if (seq_err !== 1'b1) begin tests_failed++; $display("FAIL err_b_flag got %b want 1", seq_err); end
        step(S_IDLE, 8'h00);
        clr_err = 1'b1;
        step(S_IDLE, 8'h00);
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL err_clr2 got %b want 0", seq_err); end
        // clear and a new error on the same edge: error wins
        step(S_BAD, 8'h00);
        clr_err = 1'b0;
        tests_run++;
        if (seq_err !== 1'b1) begin tests_failed++; $display("FAIL err_clr_vs_err got %b want 1", seq_err); end
        step(S_IDLE, 8'h00);
        clr_err = 1'b1;
        step(S_IDLE, 8'h00);
        clr_err = 1'b0;
        // after an error, LB1 is a legal restart point
        step(S_LB1, 8'h10);
        step(S_LB2, 8'h20);
        step(S_KG1, 8'h00);
        step(S_KG2, 8'h00);
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL err_seq_ok got %b want 0", seq_err); end
        // d) async reset between KG2 and ENC
        @(negedge clka);
        restart_n = 1'b0;
        #2;
        tests_run++;
        if (key !== 8'h00) begin tests_failed++; $display("FAIL err_d_key_rst got %h want 00", key); end
        state = S_ENC;
        @(negedge clka);
        restart_n = 1'b1;
        @(posedge clka);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL err_d_valid got %b want 0", out_valid); end
        tests_run++;
        if (seq_err !== 1'b1) begin tests_failed++; $display("FAIL err_d_flag got %b want 1", seq_err); end
        tests_run++;
        if (op_count !== 8'h00) begin tests_failed++; $display("FAIL err_d_count got %h want 00", op_count); end
        step(S_IDLE, 8'h00);
        clr_err = 1'b1;
        step(S_IDLE, 8'h00);
        clr_err = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b, k1, k2, x, exp_d, exp_c;
        for (int i = 0; i < 260; i++) begin
            a = 8'(i * 7 + 3);
            b = 8'(i * 13 + 1);
            step(S_LB1, a);
            step(S_LB2, b);
            step(S_KG1, 8'h00);
            step(S_KG2, 8'h00);
            step(S_ENC, 8'h00);
            k1    = {b[3:0], b[7:4]} ^ 8'hA5;
            k2    = {k1[6:0], k1[7]} + 8'h3C;
            x     = a ^ k2;
            exp_d = {x[4:0], x[7:5]};
            exp_c = (i >= 254) ? 8'hFF : 8'(i + 1);
            tests_run++;
            if (data_out !== exp_d) begin tests_failed++; $display("FAIL sat_data[%0d] got %h want %h", i, data_out, exp_d); end
            tests_run++;
            if (op_count !== exp_c) begin tests_failed++; $display("FAIL sat_count[%0d] got %h want %h", i, op_count, exp_c); end
            step(S_IDLE, 8'h00);
        end
        tests_run++;
        if (seq_err !== 1'b0) begin tests_failed++; $display("FAIL sat_err got %b want 0", seq_err); end
    endtask

    initial begin
        restart_n = 1'b1;
        state     = S_IDLE;
        data_in   = 8'h00;
        clr_err   = 1'b0;
        test_reset();
        test_encode();
        test_decode();
        test_hold();
        test_errors();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
